// File: rtl/control_unit_pkg.sv
// Mini SRC control sequencer: opcodes, states, class/ALU indices
// and the strobe bundle shared by the decoder and the sequencer.
package control_unit_pkg;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_SHR  = 5'd9;
  localparam logic [4:0] OP_SHRA = 5'd10;
  localparam logic [4:0] OP_SHL  = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_DIV  = 5'd15;
  localparam logic [4:0] OP_MUL  = 5'd16;
  localparam logic [4:0] OP_NEG  = 5'd17;
  localparam logic [4:0] OP_NOT  = 5'd18;
  localparam logic [4:0] OP_BR   = 5'd19;
  localparam logic [4:0] OP_JAL  = 5'd20;
  localparam logic [4:0] OP_JR   = 5'd21;
  localparam logic [4:0] OP_IN   = 5'd22;
  localparam logic [4:0] OP_OUT  = 5'd23;
  localparam logic [4:0] OP_MFHI = 5'd24;
  localparam logic [4:0] OP_MFLO = 5'd25;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd9
  } state_e;

  localparam int C_ALUR   = 0;
  localparam int C_ALUI   = 1;
  localparam int C_MULDIV = 2;
  localparam int C_NEGNOT = 3;
  localparam int C_LD     = 4;
  localparam int C_LDI    = 5;
  localparam int C_ST     = 6;
  localparam int C_BR     = 7;
  localparam int C_JR     = 8;
  localparam int C_JAL    = 9;
  localparam int C_IN     = 10;
  localparam int C_OUT    = 11;
  localparam int C_MFHI   = 12;
  localparam int C_MFLO   = 13;
  localparam int C_NOP    = 14;
  localparam int C_HALT   = 15;
  localparam int NCLS     = 16;

  localparam int A_ADD  = 0;
  localparam int A_SUB  = 1;
  localparam int A_AND  = 2;
  localparam int A_OR   = 3;
  localparam int A_ROR  = 4;
  localparam int A_ROL  = 5;
  localparam int A_SHR  = 6;
  localparam int A_SHRA = 7;
  localparam int A_SHL  = 8;
  localparam int A_DIV  = 9;
  localparam int A_MUL  = 10;
  localparam int A_NEG  = 11;
  localparam int A_NOT  = 12;
  localparam int NALU   = 13;

  typedef struct packed {
    logic            run;
    logic            clear_sig;
    logic            rd;
    logic            wr;
    logic            out_port_in;
    logic [NALU-1:0] alu;
    logic            lo_in;
    logic            hi_in;
    logic            con_in;
    logic            pc_in;
    logic            ir_in;
    logic            y_in;
    logic            z_in;
    logic            mar_in;
    logic            mdr_in;
    logic            ra_in;
    logic            outport_out;
    logic            c_out;
    logic            ba_out;
    logic            hi_out;
    logic            lo_out;
    logic            zhigh_out;
    logic            zlow_out;
    logic            mdr_out;
    logic            pc_out;
    logic            r_out;
    logic            gra;
    logic            grb;
    logic            grc;
    logic            r_in;
    logic            inc_pc;
  } ctrl_t;

endpackage

// File: rtl/control_unit_opcode_decode.sv
// Maps IR[31:27] to an instruction-class one-hot plus the ALU op
// that class uses; unassigned opcodes fall into the nop class.
module cu_opcode_decode
  import control_unit_pkg::*;
(
  input  logic [4:0]      op,
  output logic [NCLS-1:0] cls,
  output logic [NALU-1:0] alu
);

  always_comb begin
    cls = '0;
    alu = '0;
    unique case (op)
      OP_LD:   cls[C_LD] = 1'b1;
      OP_LDI:  cls[C_LDI] = 1'b1;
      OP_ST:   cls[C_ST] = 1'b1;
      OP_ADD:  begin cls[C_ALUR] = 1'b1; alu[A_ADD] = 1'b1; end
      OP_SUB:  begin cls[C_ALUR] = 1'b1; alu[A_SUB] = 1'b1; end
      OP_AND:  begin cls[C_ALUR] = 1'b1; alu[A_AND] = 1'b1; end
      OP_OR:   begin cls[C_ALUR] = 1'b1; alu[A_OR] = 1'b1; end
      OP_ROR:  begin cls[C_ALUR] = 1'b1; alu[A_ROR] = 1'b1; end
      OP_ROL:  begin cls[C_ALUR] = 1'b1; alu[A_ROL] = 1'b1; end
      OP_SHR:  begin cls[C_ALUR] = 1'b1; alu[A_SHR] = 1'b1; end
      OP_SHRA: begin cls[C_ALUR] = 1'b1; alu[A_SHRA] = 1'b1; end
      OP_SHL:  begin cls[C_ALUR] = 1'b1; alu[A_SHL] = 1'b1; end
      OP_ADDI: begin cls[C_ALUI] = 1'b1; alu[A_ADD] = 1'b1; end
      OP_ANDI: begin cls[C_ALUI] = 1'b1; alu[A_AND] = 1'b1; end
      OP_ORI:  begin cls[C_ALUI] = 1'b1; alu[A_OR] = 1'b1; end
      OP_DIV:  begin cls[C_MULDIV] = 1'b1; alu[A_DIV] = 1'b1; end
      OP_MUL:  begin cls[C_MULDIV] = 1'b1; alu[A_MUL] = 1'b1; end
      OP_NEG:  begin cls[C_NEGNOT] = 1'b1; alu[A_NEG] = 1'b1; end
      OP_NOT:  begin cls[C_NEGNOT] = 1'b1; alu[A_NOT] = 1'b1; end
      OP_BR:   cls[C_BR] = 1'b1;
      OP_JAL:  cls[C_JAL] = 1'b1;
      OP_JR:   cls[C_JR] = 1'b1;
      OP_IN:   cls[C_IN] = 1'b1;
      OP_OUT:  cls[C_OUT] = 1'b1;
      OP_MFHI: cls[C_MFHI] = 1'b1;
      OP_MFLO: cls[C_MFLO] = 1'b1;
      OP_HALT: cls[C_HALT] = 1'b1;
      default: cls[C_NOP] = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Mini SRC hardwired sequencer: fetch T0-T2, execute T3-T7, HALT.
// Define CU_STOP_EN to let Stop divert the end of an instruction to HALT.
module control_unit
  import control_unit_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Stop,
  input  logic        CON_FF,
  input  logic [31:0] IR,
  input  logic [1:0]  interrupt,
  output logic        Run,
  output logic        ClearSig,
  output logic        Read,
  output logic        Write,
  output logic        OutPortIn,
  output logic        ADD,
  output logic        SUB,
  output logic        AND,
  output logic        OR,
  output logic        ROR,
  output logic        ROL,
  output logic        SHR,
  output logic        SHRA,
  output logic        SHL,
  output logic        DIV,
  output logic        MUL,
  output logic        NEG,
  output logic        NOT,
  output logic        LOin,
  output logic        HIin,
  output logic        CONin,
  output logic        PCin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        MARin,
  output logic        MDRin,
  output logic        RAin,
  output logic        OutPortOut,
  output logic        Cout,
  output logic        BAout,
  output logic        HIout,
  output logic        LOout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        PCout,
  output logic        Rout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        IncPC
);

  state_e          state_q, state_d;
  logic [NCLS-1:0] cls;
  logic [NALU-1:0] alu;
  logic            is_last;
  logic            stop_req;
  ctrl_t           c;
  logic            unused_in;

  cu_opcode_decode u_dec (
    .op  (IR[31:27]),
    .cls (cls),
    .alu (alu)
  );

`ifdef CU_STOP_EN
  assign stop_req = Stop;
`else
  assign stop_req = 1'b0;
`endif

  assign unused_in = ^{interrupt, IR[26:0], Stop};

  always_comb begin
    is_last = 1'b0;
    unique case (state_q)
      S_T3: is_last = cls[C_JR] | cls[C_IN] | cls[C_OUT]
                    | cls[C_MFHI] | cls[C_MFLO] | cls[C_NOP];
      S_T4: is_last = cls[C_NEGNOT] | cls[C_JAL];
      S_T5: is_last = cls[C_ALUR] | cls[C_ALUI] | cls[C_LDI];
      S_T6: is_last = cls[C_MULDIV] | cls[C_BR];
      S_T7: is_last = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RESET: state_d = stop_req ? S_HALT : S_T0;
      S_T0:    state_d = S_T1;
      S_T1:    state_d = S_T2;
      S_T2:    state_d = S_T3;
      S_T3:    state_d = cls[C_HALT] ? S_HALT : S_T4;
      S_T4:    state_d = S_T5;
      S_T5:    state_d = S_T6;
      S_T6:    state_d = S_T7;
      S_T7:    state_d = S_T0;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
    if (is_last)
      state_d = stop_req ? S_HALT : S_T0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  // Strobes are decoded from the current state and IR.
  always_comb begin
    c = '0;
    unique case (state_q)
      S_RESET: c.clear_sig = 1'b1;
      S_T0: begin
        c.pc_out = 1'b1; c.mar_in = 1'b1; c.inc_pc = 1'b1;
      end
      S_T1: begin c.rd = 1'b1; c.mdr_in = 1'b1; end
      S_T2: begin c.mdr_out = 1'b1; c.ir_in = 1'b1; end
      S_T3: begin
        unique case (1'b1)
          cls[C_ALUR], cls[C_ALUI]: begin
            c.grb = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1;
          end
          cls[C_MULDIV]: begin
            c.gra = 1'b1; c.r_out = 1'b1; c.y_in = 1'b1;
          end
          cls[C_NEGNOT]: begin
            c.grb = 1'b1; c.r_out = 1'b1; c.alu = alu; c.z_in = 1'b1;
          end
          cls[C_LD], cls[C_LDI], cls[C_ST]: begin
            c.grb = 1'b1; c.ba_out = 1'b1; c.y_in = 1'b1;
          end
          cls[C_BR]: begin
            c.gra = 1'b1; c.r_out = 1'b1; c.con_in = 1'b1;
          end
          cls[C_JR]: begin
            c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1;
          end
          cls[C_JAL]: begin c.pc_out = 1'b1; c.ra_in = 1'b1; end
          cls[C_IN]: begin
            c.outport_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
          end
          cls[C_OUT]: begin
            c.gra = 1'b1; c.r_out = 1'b1; c.out_port_in = 1'b1;
          end
          cls[C_MFHI]: begin
            c.hi_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
          end
          cls[C_MFLO]: begin
            c.lo_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
          end
          default: ;
        endcase
      end
      S_T4: begin
        unique case (1'b1)
          cls[C_ALUR]: begin
            c.grc = 1'b1; c.r_out = 1'b1; c.alu = alu; c.z_in = 1'b1;
          end
          cls[C_ALUI]: begin
            c.c_out = 1'b1; c.alu = alu; c.z_in = 1'b1;
          end
          cls[C_MULDIV]: begin
            c.grb = 1'b1; c.r_out = 1'b1; c.alu = alu; c.z_in = 1'b1;
          end
          cls[C_NEGNOT]: begin
            c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
          end
          cls[C_LD], cls[C_LDI], cls[C_ST]: begin
            c.c_out = 1'b1; c.alu[A_ADD] = 1'b1; c.z_in = 1'b1;
          end
          cls[C_BR]: begin c.pc_out = 1'b1; c.y_in = 1'b1; end
          cls[C_JAL]: begin
            c.gra = 1'b1; c.r_out = 1'b1; c.pc_in = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        unique case (1'b1)
          cls[C_ALUR], cls[C_ALUI], cls[C_LDI]: begin
            c.zlow_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
          end
          cls[C_MULDIV]: begin c.zlow_out = 1'b1; c.lo_in = 1'b1; end
          cls[C_LD], cls[C_ST]: begin
            c.zlow_out = 1'b1; c.mar_in = 1'b1;
          end
          cls[C_BR]: begin
            c.c_out = 1'b1; c.alu[A_ADD] = 1'b1; c.z_in = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        unique case (1'b1)
          cls[C_MULDIV]: begin c.zhigh_out = 1'b1; c.hi_in = 1'b1; end
          cls[C_LD]: begin c.rd = 1'b1; c.mdr_in = 1'b1; end
          cls[C_ST]: begin
            c.gra = 1'b1; c.r_out = 1'b1; c.mdr_in = 1'b1;
          end
          cls[C_BR]: begin
            c.zlow_out = CON_FF; c.pc_in = CON_FF;
          end
          default: ;
        endcase
      end
      S_T7: begin
        unique case (1'b1)
          cls[C_LD]: begin
            c.mdr_out = 1'b1; c.gra = 1'b1; c.r_in = 1'b1;
          end
          cls[C_ST]: c.wr = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
    c.run = (state_q != S_HALT);
  end

  assign Run        = c.run;
  assign ClearSig   = c.clear_sig;
  assign Read       = c.rd;
  assign Write      = c.wr;
  assign OutPortIn  = c.out_port_in;
  assign ADD        = c.alu[A_ADD];
  assign SUB        = c.alu[A_SUB];
  assign AND        = c.alu[A_AND];
  assign OR         = c.alu[A_OR];
  assign ROR        = c.alu[A_ROR];
  assign ROL        = c.alu[A_ROL];
  assign SHR        = c.alu[A_SHR];
  assign SHRA       = c.alu[A_SHRA];
  assign SHL        = c.alu[A_SHL];
  assign DIV        = c.alu[A_DIV];
  assign MUL        = c.alu[A_MUL];
  assign NEG        = c.alu[A_NEG];
  assign NOT        = c.alu[A_NOT];
  assign LOin       = c.lo_in;
  assign HIin       = c.hi_in;
  assign CONin      = c.con_in;
  assign PCin       = c.pc_in;
  assign IRin       = c.ir_in;
  assign Yin        = c.y_in;
  assign Zin        = c.z_in;
  assign MARin      = c.mar_in;
  assign MDRin      = c.mdr_in;
  assign RAin       = c.ra_in;
  assign OutPortOut = c.outport_out;
  assign Cout       = c.c_out;
  assign BAout      = c.ba_out;
  assign HIout      = c.hi_out;
  assign LOout      = c.lo_out;
  assign Zhighout   = c.zhigh_out;
  assign Zlowout    = c.zlow_out;
  assign MDRout     = c.mdr_out;
  assign PCout      = c.pc_out;
  assign Rout       = c.r_out;
  assign Gra        = c.gra;
  assign Grb        = c.grb;
  assign Grc        = c.grc;
  assign Rin        = c.r_in;
  assign IncPC      = c.inc_pc;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction strobe scripts by name,
// random and directed instruction streams, reset, halt and Stop.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        Reset, Stop, CON_FF;
  logic [31:0] IR;
  logic [1:0]  interrupt;
  logic Run, ClearSig, Read, Write, OutPortIn;
  logic ADD, SUB, AND, OR, ROR, ROL, SHR, SHRA, SHL;
  logic DIV, MUL, NEG, NOT;
  logic LOin, HIin, CONin, PCin, IRin, Yin, Zin, MARin, MDRin, RAin;
  logic OutPortOut, Cout, BAout, HIout, LOout, Zhighout, Zlowout;
  logic MDRout, PCout, Rout, Gra, Grb, Grc, Rin, IncPC;

  int n_chk = 0;
  int n_fail = 0;

  always #5 Clock = ~Clock;

  control_unit dut (
    .Clock(Clock), .Reset(Reset), .Stop(Stop), .CON_FF(CON_FF),
    .IR(IR), .interrupt(interrupt), .Run(Run), .ClearSig(ClearSig),
    .Read(Read), .Write(Write), .OutPortIn(OutPortIn),
    .ADD(ADD), .SUB(SUB), .AND(AND), .OR(OR), .ROR(ROR), .ROL(ROL),
    .SHR(SHR), .SHRA(SHRA), .SHL(SHL), .DIV(DIV), .MUL(MUL),
    .NEG(NEG), .NOT(NOT), .LOin(LOin), .HIin(HIin), .CONin(CONin),
    .PCin(PCin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .MARin(MARin),
    .MDRin(MDRin), .RAin(RAin), .OutPortOut(OutPortOut), .Cout(Cout),
    .BAout(BAout), .HIout(HIout), .LOout(LOout),
    .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
    .PCout(PCout), .Rout(Rout), .Gra(Gra), .Grb(Grb), .Grc(Grc),
    .Rin(Rin), .IncPC(IncPC)
  );

  string nm [42] = '{
    "ClearSig", "Read", "Write", "OutPortIn",
    "ADD", "SUB", "AND", "OR", "ROR", "ROL", "SHR", "SHRA", "SHL",
    "DIV", "MUL", "NEG", "NOT",
    "LOin", "HIin", "CONin", "PCin", "IRin", "Yin", "Zin",
    "MARin", "MDRin", "RAin",
    "OutPortOut", "Cout", "BAout", "HIout", "LOout",
    "Zhighout", "Zlowout", "MDRout", "PCout",
    "Rout", "Gra", "Grb", "Grc", "Rin", "IncPC"};

  logic [41:0] obs;
  assign obs = {ClearSig, Read, Write, OutPortIn,
    ADD, SUB, AND, OR, ROR, ROL, SHR, SHRA, SHL, DIV, MUL, NEG, NOT,
    LOin, HIin, CONin, PCin, IRin, Yin, Zin, MARin, MDRin, RAin,
    OutPortOut, Cout, BAout, HIout, LOout, Zhighout, Zlowout,
    MDRout, PCout, Rout, Gra, Grb, Grc, Rin, IncPC};

  string alu_r [9] = '{"ADD", "SUB", "AND", "OR", "ROR", "ROL",
                       "SHR", "SHRA", "SHL"};
  string alu_i [3] = '{"ADD", "AND", "OR"};

  string exp_q [$];

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Turn a space-separated list of strobe names into the obs layout.
  function automatic logic [41:0] enc(input string s);
    logic [41:0] v;
    string tok;
    v = '0;
    tok = "";
    for (int i = 0; i <= s.len(); i++) begin
      if (i == s.len() || s[i] == 8'h20) begin
        for (int j = 0; j < 42; j++)
          if (tok.len() > 0 && nm[j] == tok) v[41-j] = 1'b1;
        tok = "";
      end else begin
        tok = {tok, s.substr(i, i)};
      end
    end
    return v;
  endfunction

  function automatic void model(input logic [4:0] op, input logic con);
    int k;
    k = int'(op);
    exp_q = {"PCout MARin IncPC", "Read MDRin", "MDRout IRin"};
    if (k == 0) begin
      exp_q.push_back("Grb BAout Yin");
      exp_q.push_back("Cout ADD Zin");
      exp_q.push_back("Zlowout MARin");
      exp_q.push_back("Read MDRin");
      exp_q.push_back("MDRout Gra Rin");
    end else if (k == 1) begin
      exp_q.push_back("Grb BAout Yin");
      exp_q.push_back("Cout ADD Zin");
      exp_q.push_back("Zlowout Gra Rin");
    end else if (k == 2) begin
      exp_q.push_back("Grb BAout Yin");
      exp_q.push_back("Cout ADD Zin");
      exp_q.push_back("Zlowout MARin");
      exp_q.push_back("Gra Rout MDRin");
      exp_q.push_back("Write");
    end else if (k >= 3 && k <= 11) begin
      exp_q.push_back("Grb Rout Yin");
      exp_q.push_back({"Grc Rout ", alu_r[k-3], " Zin"});
      exp_q.push_back("Zlowout Gra Rin");
    end else if (k >= 12 && k <= 14) begin
      exp_q.push_back("Grb Rout Yin");
      exp_q.push_back({"Cout ", alu_i[k-12], " Zin"});
      exp_q.push_back("Zlowout Gra Rin");
    end else if (k == 15 || k == 16) begin
      exp_q.push_back("Gra Rout Yin");
      exp_q.push_back({"Grb Rout ", (k == 15) ? "DIV" : "MUL", " Zin"});
      exp_q.push_back("Zlowout LOin");
      exp_q.push_back("Zhighout HIin");
    end else if (k == 17 || k == 18) begin
      exp_q.push_back({"Grb Rout ", (k == 17) ? "NEG" : "NOT", " Zin"});
      exp_q.push_back("Zlowout Gra Rin");
    end else if (k == 19) begin
      exp_q.push_back("Gra Rout CONin");
      exp_q.push_back("PCout Yin");
      exp_q.push_back("Cout ADD Zin");
      exp_q.push_back(con ? "Zlowout PCin" : "");
    end else if (k == 20) begin
      exp_q.push_back("PCout RAin");
      exp_q.push_back("Gra Rout PCin");
    end else if (k == 21) exp_q.push_back("Gra Rout PCin");
    else if (k == 22) exp_q.push_back("OutPortOut Gra Rin");
    else if (k == 23) exp_q.push_back("Gra Rout OutPortIn");
    else if (k == 24) exp_q.push_back("HIout Gra Rin");
    else if (k == 25) exp_q.push_back("LOout Gra Rin");
    else exp_q.push_back("");
  endfunction

  // Steps through one instruction; IR is only valid from T3 on.
  task automatic run_instr(input logic [31:0] ir, input logic con,
                           input int nsteps);
    int n;
    model(ir[31:27], con);
    n = exp_q.size();
    if (nsteps > 0 && nsteps < n) n = nsteps;
    for (int i = 0; i < n; i++) begin
      @(posedge Clock); #1;
      check($sformatf("op%0d_t%0d", ir[31:27], i), 64'(obs),
            64'(enc(exp_q[i])));
      check($sformatf("op%0d_t%0d_run", ir[31:27], i), 64'(Run), 64'd1);
      if (i == 0) begin
        IR = $urandom;
        CON_FF = 1'($urandom);
        interrupt = 2'($urandom);
      end
      if (i == 2) begin
        IR = ir;
        CON_FF = con;
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    Reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      @(posedge Clock); #1;
      check("rst_clr", 64'(obs), 64'(enc("ClearSig")));
      check("rst_run", 64'(Run), 64'd1);
    end
    Reset = 1'b0;
    check("rel_clr", 64'(obs), 64'(enc("ClearSig")));
    check("rel_run", 64'(Run), 64'd1);
  endtask

  initial begin
    logic [4:0] op;
    Reset = 1'b1;
    Stop = 1'b0;
    CON_FF = 1'b0;
    IR = '0;
    interrupt = '0;

    do_reset(2);
    run_instr(32'h1891_8000, 1'b0, 0);
    run_instr(32'h0088_0014, 1'b0, 0);
    run_instr(32'h9800_0000, 1'b1, 0);
    run_instr(32'h9800_0000, 1'b0, 0);
    run_instr(32'h1000_0000, 1'b0, 0);

    for (int r = 0; r < 60; r++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd27) op = 5'd26;
      run_instr({op, 27'($urandom)}, 1'($urandom), 0);
    end
    run_instr(32'hD000_0000, 1'b0, 0);

    // Reset abandons an ld half way through execute.
    run_instr(32'h0088_0014, 1'b0, 5);
    do_reset(1);
    run_instr(32'h6000_0000, 1'b1, 0);

    Stop = 1'b1;
    run_instr(32'h1891_8000, 1'b0, 0);
    @(posedge Clock); #1;
`ifdef CU_STOP_EN
    check("stop_vec", 64'(obs), 64'd0);
    check("stop_run", 64'(Run), 64'd0);
`else
    check("nostop_vec", 64'(obs), 64'(enc("PCout MARin IncPC")));
    check("nostop_run", 64'(Run), 64'd1);
`endif
    Stop = 1'b0;
    do_reset(1);

    run_instr(32'hD800_0000, 1'b0, 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge Clock); #1;
      check($sformatf("halt_vec%0d", i), 64'(obs), 64'd0);
      check($sformatf("halt_run%0d", i), 64'(Run), 64'd0);
      IR = $urandom;
      CON_FF = 1'($urandom);
      interrupt = 2'($urandom);
    end
    do_reset(1);
    run_instr(32'h1891_8000, 1'b0, 0);
    run_instr(32'h0088_0014, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired, one-hot-output control sequencer for the Mini SRC processor. It fetches each instruction, decodes `IR[31:27]`, and steps through fixed execute cycles. In each cycle it drives the DataPath strobes: register-file select/enables, bus-source selects, ALU op, memory read/write and I/O. It sits between the system clock divider output and DataPath, and signals halt through `Run`.

## Interface
- No parameters.
- `Clock`  in  1  operating clock; all state changes on its rising edge.
- `Reset`  in  1  synchronous, active-high.
- `Stop`  in  1  external halt request; only active with `CU_STOP_EN`.
- `CON_FF`  in  1  branch-condition flip-flop from DataPath.
- `IR`  in  32  current instruction register contents.
- `interrupt`  in  2  reserved; ignored.
- `Run`  out  1  1 = executing, 0 = halted.
- `ClearSig`  out  1  DataPath register clear.
- `Read`, `Write`, `OutPortIn`  out  1 each  memory read, memory write, output-port load.
- `ADD SUB AND OR ROR ROL SHR SHRA SHL DIV MUL NEG NOT`  out  1 each  ALU op select, at most one high.
- `LOin HIin CONin PCin IRin Yin Zin MARin MDRin RAin`  out  1 each  register load enables.
- `OutPortOut Cout BAout HIout LOout Zhighout Zlowout MDRout PCout Rout`  out  1 each  bus-source selects, at most one high.
- `Gra Grb Grc Rin IncPC`  out  1 each  register-field select, GPR write, PC increment.

## Operation
- Opcode map for `IR[31:27]`:
  - ld=0, ldi=1, st=2, add=3, sub=4, and=5, or=6, ror=7, rol=8, shr=9, shra=10, shl=11.
  - addi=12, andi=13, ori=14, div=15, mul=16, neg=17, not=18, br=19, jal=20, jr=21.
  - in=22, out=23, mfhi=24, mflo=25, nop=26, halt=27.
  - 28–31 execute as nop.
- States: RESET, T0–T7, HALT. Every output not listed for a state is 0.
- Fetch sequence:
  - RESET: `ClearSig`.
  - T0: `PCout MARin IncPC`.
  - T1: `Read MDRin`.
  - T2: `MDRout IRin`.
- Execute, T3 onward. The last listed step returns to T0.
  - Register ALU ops (add…shl): T3 `Grb Rout Yin`; T4 `Grc Rout op Zin`; T5 `Zlowout Gra Rin`.
  - addi/andi/ori: T3 `Grb Rout Yin`; T4 `Cout op Zin` (op = ADD/AND/OR); T5 `Zlowout Gra Rin`.
  - mul/div: T3 `Gra Rout Yin`; T4 `Grb Rout op Zin`; T5 `Zlowout LOin`; T6 `Zhighout HIin`.
  - neg/not: T3 `Grb Rout op Zin`; T4 `Zlowout Gra Rin`.
  - ld: T3 `Grb BAout Yin`; T4 `Cout ADD Zin`; T5 `Zlowout MARin`; T6 `Read MDRin`; T7 `MDRout Gra Rin`.
  - ldi: T3–T4 as ld; T5 `Zlowout Gra Rin`.
  - st: T3–T5 as ld; T6 `Gra Rout MDRin`; T7 `Write`.
  - br: T3 `Gra Rout CONin`; T4 `PCout Yin`; T5 `Cout ADD Zin`; T6 `Zlowout PCin` only if `CON_FF`=1, otherwise idle.
  - jr: T3 `Gra Rout PCin`.
  - jal: T3 `PCout RAin`; T4 `Gra Rout PCin`.
  - in: T3 `OutPortOut Gra Rin`.
  - out: T3 `Gra Rout OutPortIn`.
  - mfhi / mflo: T3 `HIout` / `LOout` with `Gra Rin`.
  - nop: T3 idle.
  - halt: T3 goes to HALT.
- `Run`=0 only in HALT. HALT holds, with all strobes 0, until `Reset`.

## Timing
- `Reset` sampled high → state RESET on that edge.
- RESET lasts while `Reset`=1, then one more cycle, then T0.
- Reset has priority over every state, including mid-instruction and HALT.
- Outputs are combinational from the state register and `IR`/`CON_FF`; they are valid for the whole state cycle.
- `IR` decode is valid from T3; IR loads at the end of T2.
- Instruction latency, T0 through last step:
  - 8 cycles: ld, st.
  - 7 cycles: mul, div, br.
  - 6 cycles: register/immediate ALU ops, ldi.
  - 5 cycles: neg, not, jal.
  - 4 cycles: others.

## Configuration
- `CU_STOP_EN` defined: `Stop` is sampled at the last step of each instruction (and at T0 entry from RESET). If 1, the next state is HALT instead of T0.
- `CU_STOP_EN` undefined: `Stop` is ignored.

## Structure
- Package `control_unit_pkg`: opcode constants (5-bit) and the state enumeration (4-bit).
- One combinational sub-module `cu_opcode_decode` maps `IR[31:27]` to an instruction-class one-hot. The FSM and output logic stay in `control_unit`.

## Test plan
- Reset held 2 cycles, then released:
  - `ClearSig`=1 during reset and for the first cycle after release, `Run`=1.
  - T0 asserts `PCout MARin IncPC`.
- IR=0x1891_8000 (add r1,r2,r3):
  - T3 `Grb Rout Yin`; T4 `Grc Rout ADD Zin`; T5 `Zlowout Gra Rin`.
  - Back to T0 after 6 cycles.
- IR=0x0088_0014 (ld r1,0x14(r1)): T6 `Read MDRin`, T7 `MDRout Gra Rin`, 8-cycle instruction.
- IR=0x9800_0000 (br): with `CON_FF`=1, T6 asserts `Zlowout PCin`; with `CON_FF`=0, T6 has no strobes.
- IR=0xD800_0000 (halt): `Run` falls after T3 and stays 0 for 10 cycles. `Reset` restores `Run`=1.
- `CU_STOP_EN` with `Stop`=1 during an add: completes T5, then HALT, `Run`=0.
